byte_mem_ctrl: RTL
==================

# byte_mem_ctrl

Parametrised byte-serial memory controller between the core's two memory clients and the single 8-bit RAM/IO bus. It serves instruction-line fetches of configurable length and LSB loads/stores of 1/2/4 bytes, arbitrates fairly between them, and sign-extends loads. Reads can be aborted on rollback; committed stores always finish. It sits between the fetch unit, the load/store buffer and the top-level `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins.

## Interface
- `IF_LINE_BYTES`, default 64: bytes per fetch line, ≥4, power of 2.
- `ADDR_W`, default 32: width of `mem_a` and of all request addresses.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; low freezes the block.
- `rollback` in 1: flush from the ROB.
- `mem_din` in 8: RAM/IO read byte; valid one edge after its address.
- `mem_dout` out 8: write byte.
- `mem_a` out ADDR_W: byte address.
- `mem_wr` out 1: 1 = write.
- `io_buffer_full` in 1: UART buffer full.
- `if_en` in 1: fetch request, level; held until `if_done`.
- `if_pc` in ADDR_W: line address.
- `if_data` out 8*IF_LINE_BYTES: line, byte k at bits [8k+7:8k].
- `if_done` out 1: one-cycle completion pulse.
- `lsb_en` in 1: LSB request, level; held until `lsb_done`.
- `lsb_wr` in 1: 1 = store.
- `lsb_len` in 3: byte count, legal values 1, 2, 4.
- `lsb_signed` in 1: sign-extend the load result.
- `lsb_addr` in ADDR_W: first byte address.
- `lsb_w_data` in 32: store data, LSB first.
- `lsb_r_data` out 32: load result.
- `lsb_done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, FETCH, LOAD, STORE. Counter `stage`, width $clog2(IF_LINE_BYTES)+1.
- Reset: state IDLE; `mem_a`=0, `mem_wr`=0, `mem_dout`=0, `if_done`=0, `lsb_done`=0, `lsb_r_data`=0, `if_data`=0, last-grant=IF.
- `rdy`=0: no state, counter or output changes, except that `mem_wr` is forced to 0 for that cycle.
- IDLE behaviour:
  - If a done pulse is high, clear it and accept nothing this edge.
  - Else if `rollback`=1, accept nothing.
  - Else grant a request:
    - Only one of `lsb_en`/`if_en` is high: that one wins.
    - Both high: LSB wins, unless the last grant was LSB, in which case IF wins.
    - Record the winner as last-grant.
- FETCH/LOAD, N = IF_LINE_BYTES or `lsb_len`:
  - Edge E0 (accept): `mem_a`<=addr.
  - Edge Ek, k=1..N: capture `mem_din` as byte k-1; `mem_a`<=addr+k for k<N, else 0.
  - At E_N: done<=1, state IDLE.
  - LOAD result: zero-extended, or sign-extended from bit 8N-1 if `lsb_signed`=1 (inputs latched at E0).
- Rollback sampled high in FETCH or LOAD: go to IDLE, `mem_a`<=0, no done, outputs left partial/undefined.
- STORE:
  - E0 latches addr, data and len.
  - Edge Ek, k=1..N: `mem_wr`<=1, `mem_a`<=addr+k-1, `mem_dout`<=byte k-1.
  - At E_N: `lsb_done`<=1, state IDLE.
  - The next edge drives `mem_wr`<=0.
  - STORE ignores rollback.
- IO region is addr[17:16]==2'b11 (see Configuration).
- `if_data`/`lsb_r_data` are stable from the done pulse until the next accept on that channel.

## Timing
- Read latency: request seen at E0 → done high after E_N (N+1 edges). 4-byte load: 5. 64-byte fetch: 65.
- Store latency: N+1 edges to `lsb_done`. Last byte is written in the same cycle `lsb_done` is high.
- Back-to-back: the earliest next accept is E_N+2, because IDLE spends one edge clearing the done pulse.
- Address arithmetic is modulo 2^ADDR_W, with no wrap special-case.

## Configuration
- `BYTE_MEM_CTRL_IO_STALL_EN` defined: in STORE, an edge with `io_buffer_full`=1 and IO address makes no progress: `stage` holds and `mem_wr`<=0. The byte is retried on the next edge.
- Undefined: `io_buffer_full` is ignored.

## Structure
- Shared package `mem_ctrl_pkg`:
  - state encoding (IDLE=0, FETCH=1, LOAD=2, STORE=3);
  - IO region constant 2'b11 and its bit position [17:16];
  - legal `lsb_len` values;
  - a sign-extend function.
- Sub-module `if_line_buf`: IF_LINE_BYTES×8 register array written by byte index, packed onto `if_data`.

## Test plan
- Reset, then `lsb_en` load len=4 @0x100, RAM bytes 0x80,0x00,0x00,0x00 → `lsb_done` 5 edges after accept, `lsb_r_data`=0x00000080.
- Load len=1 signed @0x10 with byte 0xF0 → 0xFFFFFFF0. Same load with `lsb_signed`=0 → 0x000000F0.
- `if_en` and `lsb_en` held high continuously → grants alternate LSB, IF, LSB, IF. A 64-byte line matches RAM contents at `if_pc`.
- Store 0xDEADBEEF len=4 @0x200 → `mem_wr` high for 4 cycles at 0x200..0x203 with bytes EF,BE,AD,DE. Rollback mid-store → store still completes.
- Rollback asserted 10 edges into a fetch → no `if_done`, next accept at least 1 edge later, `mem_a`=0.
- With macro defined: store len=1 to 0x30000 while `io_buffer_full`=1 for 3 edges → no `mem_wr` during those edges. Write happens the edge after it drops.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: state encoding,
// IO region decode, legal LSB access lengths and load sign extension.
package mem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_STORE = 2'd3;

    localparam logic [1:0]  IO_REGION = 2'b11;
    localparam int unsigned IO_BIT_HI = 17;
    localparam int unsigned IO_BIT_LO = 16;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;

    // Map any request length onto a legal one so a bad length cannot hang a transfer.
    function automatic logic [2:0] legal_len(input logic [2:0] len);
        case (len)
            LEN_BYTE: legal_len = LEN_BYTE;
            LEN_HALF: legal_len = LEN_HALF;
            default:  legal_len = LEN_WORD;
        endcase
    endfunction

    // Zero- or sign-extend the low len bytes of data to 32 bits.
    function automatic logic [31:0] sign_extend(input logic [31:0] data,
                                                input logic [2:0]  len,
                                                input logic        is_signed);
        case (len)
            LEN_BYTE: sign_extend = {{24{is_signed & data[7]}}, data[7:0]};
            LEN_HALF: sign_extend = {{16{is_signed & data[15]}}, data[15:0]};
            default:  sign_extend = data;
        endcase
    endfunction

endpackage

// File: rtl/if_line_buf.sv
// Instruction line buffer: byte-addressed register array packed onto one wide bus.
module if_line_buf #(
    parameter int unsigned LINE_BYTES = 64,
    localparam int unsigned IW = $clog2(LINE_BYTES)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic [IW-1:0]           i_idx,
    input  logic [7:0]              i_data,
    output logic [8*LINE_BYTES-1:0] o_line
);

    logic [7:0] r_bytes [LINE_BYTES];

    // Store one fetched byte at its line offset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < int'(LINE_BYTES); k++) begin
                r_bytes[k] <= 8'h00;
            end
        end else if (i_we) begin
            r_bytes[i_idx] <= i_data;
        end
    end

    // Pack byte k onto bits [8k+7:8k].
    always_comb begin
        for (int k = 0; k < int'(LINE_BYTES); k++) begin
            o_line[8*k +: 8] = r_bytes[k];
        end
    end

endmodule

// File: rtl/byte_mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and LSB traffic
// onto one 8-bit RAM/IO bus. Optional feature macro: BYTE_MEM_CTRL_IO_STALL_EN
// (stall IO-region store bytes while the UART buffer is full).
module byte_mem_ctrl #(
    parameter int unsigned IF_LINE_BYTES = 64,
    parameter int unsigned ADDR_W        = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_rdy,
    input  logic                       i_rollback,
    input  logic [7:0]                 i_mem_din,
    output logic [7:0]                 o_mem_dout,
    output logic [ADDR_W-1:0]          o_mem_a,
    output logic                       o_mem_wr,
    input  logic                       i_io_buffer_full,
    input  logic                       i_if_en,
    input  logic [ADDR_W-1:0]          i_if_pc,
    output logic [8*IF_LINE_BYTES-1:0] o_if_data,
    output logic                       o_if_done,
    input  logic                       i_lsb_en,
    input  logic                       i_lsb_wr,
    input  logic [2:0]                 i_lsb_len,
    input  logic                       i_lsb_signed,
    input  logic [ADDR_W-1:0]          i_lsb_addr,
    input  logic [31:0]                i_lsb_w_data,
    output logic [31:0]                o_lsb_r_data,
    output logic                       o_lsb_done
);
    import mem_ctrl_pkg::*;

    localparam int unsigned IW = $clog2(IF_LINE_BYTES);
    localparam int unsigned SW = IW + 1;

    logic [1:0]        r_state,      w_state_nx;
    logic [SW-1:0]     r_stage,      w_stage_nx;
    logic [ADDR_W-1:0] r_addr,       w_addr_nx;
    logic [2:0]        r_len,        w_len_nx;
    logic              r_signed,     w_signed_nx;
    logic [31:0]       r_wdata,      w_wdata_nx;
    logic [31:0]       r_ld_data,    w_ld_data_nx;
    logic              r_last_lsb,   w_last_lsb_nx;
    logic [ADDR_W-1:0] r_mem_a,      w_mem_a_nx;
    logic              r_mem_wr,     w_mem_wr_nx;
    logic [7:0]        r_mem_dout,   w_mem_dout_nx;
    logic              r_if_done,    w_if_done_nx;
    logic              r_lsb_done,   w_lsb_done_nx;
    logic [31:0]       r_lsb_r_data, w_lsb_r_data_nx;

    logic              w_lb_we;
    logic [SW-1:0]     w_stage_inc;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_if_last;
    logic              w_lsb_last;
    logic [4:0]        w_byte_sh;
    logic [31:0]       w_ld_merged;
    logic [7:0]        w_st_byte;
    logic              w_grant_lsb;
    logic              w_io_stall;

    assign w_stage_inc = r_stage + SW'(1);
    assign w_cur_addr  = r_addr + ADDR_W'(r_stage);
    assign w_next_addr = r_addr + ADDR_W'(w_stage_inc);
    assign w_if_last   = (w_stage_inc == SW'(IF_LINE_BYTES));
    assign w_lsb_last  = (w_stage_inc == SW'(r_len));
    assign w_byte_sh   = {r_stage[1:0], 3'b000};
    assign w_ld_merged = (r_ld_data & ~(32'h0000_00FF << w_byte_sh))
                       | (32'(i_mem_din) << w_byte_sh);
    assign w_st_byte   = r_wdata[w_byte_sh +: 8];
    // LSB wins a tie unless it won the previous grant.
    assign w_grant_lsb = i_lsb_en && (!i_if_en || !r_last_lsb);

`ifdef BYTE_MEM_CTRL_IO_STALL_EN
    assign w_io_stall = i_io_buffer_full
                     && (w_cur_addr[IO_BIT_HI:IO_BIT_LO] == IO_REGION);
`else
    assign w_io_stall = 1'b0;
    wire   w_unused_io = i_io_buffer_full;
`endif

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_stage      <= '0;
            r_addr       <= '0;
            r_len        <= LEN_WORD;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
            r_ld_data    <= '0;
            r_last_lsb   <= 1'b0;
            r_mem_a      <= '0;
            r_mem_wr     <= 1'b0;
            r_mem_dout   <= '0;
            r_if_done    <= 1'b0;
            r_lsb_done   <= 1'b0;
            r_lsb_r_data <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_stage      <= w_stage_nx;
            r_addr       <= w_addr_nx;
            r_len        <= w_len_nx;
            r_signed     <= w_signed_nx;
            r_wdata      <= w_wdata_nx;
            r_ld_data    <= w_ld_data_nx;
            r_last_lsb   <= w_last_lsb_nx;
            r_mem_a      <= w_mem_a_nx;
            r_mem_wr     <= w_mem_wr_nx;
            r_mem_dout   <= w_mem_dout_nx;
            r_if_done    <= w_if_done_nx;
            r_lsb_done   <= w_lsb_done_nx;
            r_lsb_r_data <= w_lsb_r_data_nx;
        end
    end

    // Next-state and output logic; everything holds unless rdy, mem_wr defaults low.
    always_comb begin
        w_state_nx      = r_state;
        w_stage_nx      = r_stage;
        w_addr_nx       = r_addr;
        w_len_nx        = r_len;
        w_signed_nx     = r_signed;
        w_wdata_nx      = r_wdata;
        w_ld_data_nx    = r_ld_data;
        w_last_lsb_nx   = r_last_lsb;
        w_mem_a_nx      = r_mem_a;
        w_mem_wr_nx     = 1'b0;
        w_mem_dout_nx   = r_mem_dout;
        w_if_done_nx    = r_if_done;
        w_lsb_done_nx   = r_lsb_done;
        w_lsb_r_data_nx = r_lsb_r_data;
        w_lb_we         = 1'b0;

        if (i_rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_if_done || r_lsb_done) begin
                        w_if_done_nx  = 1'b0;
                        w_lsb_done_nx = 1'b0;
                    end else if (!i_rollback) begin
                        if (w_grant_lsb) begin
                            w_last_lsb_nx = 1'b1;
                            w_stage_nx    = '0;
                            w_addr_nx     = i_lsb_addr;
                            w_len_nx      = legal_len(i_lsb_len);
                            w_signed_nx   = i_lsb_signed;
                            w_wdata_nx    = i_lsb_w_data;
                            if (i_lsb_wr) begin
                                w_state_nx = ST_STORE;
                            end else begin
                                w_state_nx = ST_LOAD;
                                w_mem_a_nx = i_lsb_addr;
                            end
                        end else if (i_if_en) begin
                            w_last_lsb_nx = 1'b0;
                            w_stage_nx    = '0;
                            w_addr_nx     = i_if_pc;
                            w_state_nx    = ST_FETCH;
                            w_mem_a_nx    = i_if_pc;
                        end
                    end
                end
                ST_FETCH: begin
                    if (i_rollback) begin
                        w_state_nx = ST_IDLE;
                        w_mem_a_nx = '0;
                    end else begin
                        w_lb_we = 1'b1;
                        if (w_if_last) begin
                            w_state_nx   = ST_IDLE;
                            w_mem_a_nx   = '0;
                            w_if_done_nx = 1'b1;
                        end else begin
                            w_stage_nx = w_stage_inc;
                            w_mem_a_nx = w_next_addr;
                        end
                    end
                end
                ST_LOAD: begin
                    if (i_rollback) begin
                        w_state_nx = ST_IDLE;
                        w_mem_a_nx = '0;
                    end else begin
                        w_ld_data_nx = w_ld_merged;
                        if (w_lsb_last) begin
                            w_state_nx      = ST_IDLE;
                            w_mem_a_nx      = '0;
                            w_lsb_done_nx   = 1'b1;
                            w_lsb_r_data_nx = sign_extend(w_ld_merged, r_len, r_signed);
                        end else begin
                            w_stage_nx = w_stage_inc;
                            w_mem_a_nx = w_next_addr;
                        end
                    end
                end
                ST_STORE: begin
                    if (!w_io_stall) begin
                        w_mem_wr_nx   = 1'b1;
                        w_mem_a_nx    = w_cur_addr;
                        w_mem_dout_nx = w_st_byte;
                        w_stage_nx    = w_stage_inc;
                        if (w_lsb_last) begin
                            w_state_nx    = ST_IDLE;
                            w_lsb_done_nx = 1'b1;
                        end
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    if_line_buf #(
        .LINE_BYTES (IF_LINE_BYTES)
    ) u_line_buf (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_lb_we),
        .i_idx  (r_stage[IW-1:0]),
        .i_data (i_mem_din),
        .o_line (o_if_data)
    );

    assign o_mem_a      = r_mem_a;
    assign o_mem_wr     = r_mem_wr;
    assign o_mem_dout   = r_mem_dout;
    assign o_if_done    = r_if_done;
    assign o_lsb_done   = r_lsb_done;
    assign o_lsb_r_data = r_lsb_r_data;

endmodule
